down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/fir_pkg.sv | 13 +
 rtl/down_counter_if.sv | 27 ++
 rtl/down_counter_jk_ff.sv | 24 ++
 rtl/down_counter.sv | 100 ++++++++++
 tb/tb_down_counter.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared constants for the down counter: default count width and control state encoding.
// Package only, no timing or flow control.
package fir_pkg;

  localparam int COUNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_if.sv
// Control/status bundle of the down counter; master drives start/load_val/en and the counter returns op/busy/tc/done.
// Wires only, no latency; there is no backpressure, en is the only stall.
interface down_counter_if
  import fir_pkg::*;
#(
  parameter int WIDTH = COUNT_W
);

  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] op;
  logic             busy;
  logic             tc;
  logic             done;

  modport master (
    output start, load_val, en,
    input  op, busy, tc, done
  );

  modport slave (
    input  start, load_val, en,
    output op, busy, tc, done
  );

endinterface

// File: rtl/down_counter_jk_ff.sv
// JK flip-flop with asynchronous active-low clear; one bit of the counter's toggle chain.
// Q updates one clk edge after J/K; never stalls.
module jk_ff (
  input  logic clk,
  input  logic clr_n,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b01:   q <= 1'b0;
        2'b10:   q <= 1'b1;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter (IDLE -> COUNT -> DONE); op loads one edge after an accepted start.
// en low freezes an active countdown; start is honoured only in IDLE.
module down_counter
  import fir_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  down_counter_if.slave  bus
);

  state_t           state;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] lower_zero;
  logic             load;
  logic             cnt;
  logic             at_zero;

  assign at_zero = (q == '0);
  assign load    = (state == ST_IDLE) && bus.start;
  // Gating on at_zero keeps the chain from borrowing past zero.
  assign cnt     = (state == ST_COUNT) && bus.en && !at_zero;

  always_comb begin
    lower_zero    = '0;
    lower_zero[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      lower_zero[i] = lower_zero[i-1] & ~q[i-1];
    end
  end

  // A load forces J/K to set or clear each bit; counting uses J=K for toggle.
  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (load) begin
        j[i] = bus.load_val[i];
        k[i] = ~bus.load_val[i];
      end else begin
        j[i] = cnt & lower_zero[i];
        k[i] = cnt & lower_zero[i];
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    jk_ff u_jk (
      .clk   (clk),
      .clr_n (rst_n),
      .j     (j[g]),
      .k     (k[g]),
      .q     (q[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state  <= ST_COUNT;
            busy_r <= 1'b1;
          end
        end
        ST_COUNT: begin
          if (bus.en && at_zero) begin
            state  <= ST_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.op   = q;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.tc   = busy_r && at_zero;

endmodule

// File: tb/tb_down_counter.sv
// Directed bench for down_counter: each scenario task drives vectors and compares {op,busy,tc,done} inline.
module tb_down_counter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  down_counter_if #(.WIDTH(4)) dif ();

  down_counter #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observed status packed as {op, busy, tc, done}.
  function automatic logic [6:0] obs();
    return {dif.op, dif.busy, dif.tc, dif.done};
  endfunction

  task automatic test_reset();
    logic [6:0] exp_v;
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_state: got %h expected %h", obs(), exp_v);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [6:0] exp_v;
    int busy_cycles;
    busy_cycles = 0;
    dif.start = 1'b1; dif.load_val = 4'd5; dif.en = 1'b1;
    step();
    dif.start = 1'b0;
    for (int v = 5; v >= 0; v--) begin
      exp_v = {4'(v), 1'b1, (v == 0), 1'b0};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL basic_seq v=%0d: got %h expected %h", v, obs(), exp_v);
      end
      if (dif.busy) busy_cycles++;
      step();
    end
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL basic_done: got %h expected %h", obs(), exp_v);
    end
    n_cmp++;
    if (busy_cycles !== 6) begin
      n_err++;
      $display("FAIL basic_busy_len: got %0d expected 6", busy_cycles);
    end
    step();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL basic_idle: got %h expected %h", obs(), exp_v);
    end
  endtask

  task automatic test_zero_load();
    logic [6:0] exp_v;
    dif.start = 1'b1; dif.load_val = 4'd0; dif.en = 1'b1;
    step();
    dif.start = 1'b0;
    exp_v = {4'd0, 1'b1, 1'b1, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL zero_count: got %h expected %h", obs(), exp_v);
    end
    step();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL zero_done: got %h expected %h", obs(), exp_v);
    end
    dif.en = 1'b0;
    step();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL zero_idle: got %h expected %h", obs(), exp_v);
    end
  endtask

  task automatic test_enable_gating();
    logic [6:0] exp_v;
    int en_cycles;
    en_cycles = 0;
    dif.start = 1'b1; dif.load_val = 4'd9; dif.en = 1'b1;
    step();
    dif.start = 1'b0;
    for (int v = 9; v >= 0; v--) begin
      exp_v = {4'(v), 1'b1, (v == 0), 1'b0};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL en_seq v=%0d: got %h expected %h", v, obs(), exp_v);
      end
      if (v == 7) begin
        dif.en = 1'b0;
        for (int h = 0; h < 3; h++) begin
          step();
          exp_v = {4'd7, 1'b1, 1'b0, 1'b0};
          n_cmp++;
          if (obs() !== exp_v) begin
            n_err++;
            $display("FAIL en_hold h=%0d: got %h expected %h", h, obs(), exp_v);
          end
        end
        dif.en = 1'b1;
      end
      if (dif.busy && dif.en) en_cycles++;
      step();
    end
    n_cmp++;
    if (dif.done !== 1'b1 || en_cycles !== 10) begin
      n_err++;
      $display("FAIL en_total: got done=%0b cycles=%0d expected done=1 cycles=10", dif.done, en_cycles);
    end
    step();
  endtask

  task automatic test_ignored_start();
    logic [6:0] exp_v;
    dif.start = 1'b1; dif.load_val = 4'd6; dif.en = 1'b1;
    step();
    for (int v = 6; v >= 0; v--) begin
      dif.start = 1'b0;
      exp_v = {4'(v), 1'b1, (v == 0), 1'b0};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL ign_seq v=%0d: got %h expected %h", v, obs(), exp_v);
      end
      if (v == 4) begin dif.start = 1'b1; dif.load_val = 4'd3; end
      if (v == 2) begin dif.start = 1'b1; dif.load_val = 4'd9; end
      step();
    end
    dif.start = 1'b1; dif.load_val = 4'd5;
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL ign_done: got %h expected %h", obs(), exp_v);
    end
    step();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL ign_start_in_done: got %h expected %h", obs(), exp_v);
    end
    dif.load_val = 4'd2;
    step();
    dif.start = 1'b0;
    exp_v = {4'd2, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL first_idle_start: got %h expected %h", obs(), exp_v);
    end
    step(); step(); step();
    n_cmp++;
    if (dif.done !== 1'b1) begin
      n_err++;
      $display("FAIL first_idle_done: got %0b expected 1", dif.done);
    end
    step();
  endtask

  task automatic test_mid_reset();
    logic [6:0] exp_v;
    int done_seen;
    done_seen = 0;
    dif.start = 1'b1; dif.load_val = 4'd15; dif.en = 1'b1;
    step();
    dif.start = 1'b0;
    for (int s = 0; s < 7; s++) step();
    exp_v = {4'd8, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL mrst_pre: got %h expected %h", obs(), exp_v);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL mrst_async: got %h expected %h", obs(), exp_v);
    end
    for (int s = 0; s < 3; s++) begin
      step();
      if (dif.done) done_seen++;
    end
    rst_n = 1'b1;
    dif.start = 1'b1; dif.load_val = 4'd3;
    step();
    dif.start = 1'b0;
    for (int v = 3; v >= 0; v--) begin
      exp_v = {4'(v), 1'b1, (v == 0), 1'b0};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL mrst_restart v=%0d: got %h expected %h", v, obs(), exp_v);
      end
      step();
    end
    n_cmp++;
    if (done_seen !== 0 || dif.done !== 1'b1) begin
      n_err++;
      $display("FAIL mrst_done: got spurious=%0d done=%0b expected spurious=0 done=1", done_seen, dif.done);
    end
    step();
  endtask

  task automatic test_full_range();
    logic [6:0] exp_v;
    int cnt_cycles;
    cnt_cycles = 0;
    dif.start = 1'b1; dif.load_val = 4'd15; dif.en = 1'b1;
    step();
    dif.start = 1'b0;
    for (int v = 15; v >= 0; v--) begin
      exp_v = {4'(v), 1'b1, (v == 0), 1'b0};
      n_cmp++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL full_seq v=%0d: got %h expected %h", v, obs(), exp_v);
      end
      if (dif.busy) cnt_cycles++;
      step();
    end
    exp_v = {4'd0, 1'b0, 1'b0, 1'b1};
    n_cmp++;
    if (obs() !== exp_v || cnt_cycles !== 16) begin
      n_err++;
      $display("FAIL full_done: got %h cycles=%0d expected %h cycles=16", obs(), cnt_cycles, exp_v);
    end
    step();
    exp_v = {4'd0, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL full_no_wrap: got %h expected %h", obs(), exp_v);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_cmp = 0;
    n_err = 0;
    dif.start = 1'b0;
    dif.load_val = '0;
    dif.en = 1'b0;
    #12;
    test_reset();
    test_basic();
    test_zero_load();
    test_enable_gating();
    test_ignored_start();
    test_mid_reset();
    test_full_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
